pipe_stage_elastic: RTL
=======================

// Module: pipe_stage_elastic
// PURPOSE
//  Parametrised elastic pipeline-stage register for the SIMD pipeline. Replaces fixed always-enabled
//  inter-stage flip-flops with a valid/ready handshake, back-pressure (stall) and synchronous flush.
//  An optional 2-entry skid buffer makes in_ready fully registered, so stalls never form long
//  combinational ready chains. One instance sits between each pair of stages (IF/ID, ID/EX, EX/MEM, MEM/WB).
// PARAMETERS
//  WIDTH  128  payload bits carried per beat (stage bundle width, e.g. 163, 270, 386, 298)
//  SKID   1    1 = two-entry skid buffer, registered in_ready; 0 = single register, combinational in_ready
// PORTS
//  clk        in   1      clock, rising edge
//  reset      in   1      asynchronous, active-high reset
//  flush      in   1      synchronous kill of all held beats (branch taken / pc_src)
//  in_valid   in   1      upstream beat present
//  in_ready   out  1      stage accepts a beat this cycle
//  in_data    in   WIDTH  upstream payload
//  out_valid  out  1      beat presented downstream
//  out_ready  in   1      downstream accepts the beat
//  out_data   out  WIDTH  downstream payload
//  occupancy  out  2      held beats: 0, 1, 2 (2 only when SKID=1)
// BEHAVIOUR
//  - Reset (async): state=PS_EMPTY; out_valid=0; out_data=0; occupancy=0; in_ready=1 (SKID=1) / 1 (SKID=0).
//  - in_fire = in_valid & in_ready; out_fire = out_valid & out_ready. Latency 1 cycle in->out; 1 beat/cycle.
//  - Downstream rule: once out_valid=1, out_valid and out_data stay stable until out_fire or flush.
//  - SKID=1 FSM (main reg M drives out_data; skid reg S):
//      PS_EMPTY: in_fire -> M<=in_data, PS_BUSY.
//      PS_BUSY : in_fire&out_fire -> M<=in_data, PS_BUSY; in_fire&!out_fire -> S<=in_data, PS_FULL;
//                !in_fire&out_fire -> PS_EMPTY; else hold.
//      PS_FULL : in_ready=0; out_fire -> M<=S, PS_BUSY; else hold.
//    in_ready = registered (next_state != PS_FULL); depends on no same-cycle input.
//  - SKID=0: states PS_EMPTY/PS_BUSY only; in_ready = !out_valid | out_ready (combinational);
//    in_fire loads M; out_fire without in_fire -> PS_EMPTY.
//  - out_valid = (state != PS_EMPTY). occupancy: EMPTY=0, BUSY=1, FULL=2.
//  - Flush: highest priority over in_fire/out_fire; next state PS_EMPTY, out_valid=0 next cycle,
//    any in_fire in the flush cycle is discarded, data regs keep stale contents (not cleared).
//  - Simultaneous flush & reset: reset wins. Reset mid-transfer drops all beats, no partial outputs.
//  - out_valid/out_data never combinationally depend on in_* (both modes).
// STRUCTURE
//  - pipeline_pkg: typedef enum logic [1:0] pipe_state_e {PS_EMPTY, PS_BUSY, PS_FULL};
//    constants VEC_W=128, PC_W=18 shared with the processor top.
//  - M and S are instances of flip_flop_D #(WIDTH) with computed enables; no other sub-module.
//  - Generate on SKID selects ready logic and omits S when SKID=0.
// TESTING
//  1. Reset asserted mid-run -> same/next edge out_valid=0, out_data=0, occupancy=0, in_ready=1.
//  2. SKID=1, out_ready=1, in_valid=1 stream 0x1,0x2,0x3 -> out_data 0x1,0x2,0x3 on consecutive
//     cycles starting 1 cycle later, occupancy stays 1.
//  3. SKID=1, out_ready=0, send 0xA,0xB -> occupancy=2, in_ready=0; 0xC held upstream;
//     raise out_ready -> out 0xA,0xB,0xC in order, nothing lost or duplicated.
//  4. SKID=1, PS_FULL, flush=1 with in_valid=1 (0xD) -> next cycle out_valid=0, occupancy=0,
//     0xD never appears at output.
//  5. SKID=0, out_valid=1, out_ready=0 -> in_ready=0 same cycle; out_ready=1 -> in_ready=1 same cycle.
//  6. Random valid/ready/flush, WIDTH=386, both SKID values -> scoreboard: in-order, stable-while-stalled.

Source files
------------

// File: rtl/pipeline_pkg.sv
// rtl/pipeline_pkg.sv - shared pipeline-stage types and processor-wide widths
package pipeline_pkg;

   typedef enum logic [1:0] {
      PS_EMPTY = 2'd0,
      PS_BUSY  = 2'd1,
      PS_FULL  = 2'd2
   } pipe_state_e;

   localparam int VEC_W = 128;
   localparam int PC_W  = 18;

   function automatic logic [1:0] state_occupancy(input pipe_state_e s);
      logic [1:0] occ;
      occ = 2'd0;
      case (s)
         PS_EMPTY: occ = 2'd0;
         PS_BUSY:  occ = 2'd1;
         PS_FULL:  occ = 2'd2;
         default:  occ = 2'd0;
      endcase
      return occ;
   endfunction

endpackage

// File: rtl/flip_flop_D.sv
// rtl/flip_flop_D.sv - enabled D register with asynchronous clear
module flip_flop_D #(
   parameter int WIDTH = 128
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/pipe_stage_elastic.sv
// rtl/pipe_stage_elastic.sv - valid/ready pipeline stage with optional two-entry skid buffer
module pipe_stage_elastic
   import pipeline_pkg::*;
#(
   parameter int WIDTH = VEC_W,
   parameter int SKID  = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [1:0]       occupancy
);

   pipe_state_e      state_q;
   pipe_state_e      state_d;
   logic             in_fire;
   logic             out_fire;
   logic             m_en;
   logic             m_sel_skid;
   logic             s_en;
   logic [WIDTH-1:0] m_d;
   logic [WIDTH-1:0] s_q;

   assign out_valid = (state_q != PS_EMPTY);
   assign occupancy = state_occupancy(state_q);
   assign in_fire   = in_valid & in_ready;
   assign out_fire  = out_valid & out_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= PS_EMPTY;
      end else begin
         state_q <= state_d;
      end
   end

   // Flush overrides both handshakes; held data regs are left stale on purpose.
   always_comb begin
      state_d    = state_q;
      m_en       = 1'b0;
      s_en       = 1'b0;
      m_sel_skid = 1'b0;
      if (flush) begin
         state_d = PS_EMPTY;
      end else begin
         case (state_q)
            PS_EMPTY: begin
               if (in_fire) begin
                  m_en    = 1'b1;
                  state_d = PS_BUSY;
               end
            end
            PS_BUSY: begin
               if (in_fire && out_fire) begin
                  m_en = 1'b1;
               end else if (in_fire && (SKID != 0)) begin
                  s_en    = 1'b1;
                  state_d = PS_FULL;
               end else if (out_fire) begin
                  state_d = PS_EMPTY;
               end
            end
            PS_FULL: begin
               if (out_fire) begin
                  m_en       = 1'b1;
                  m_sel_skid = 1'b1;
                  state_d    = PS_BUSY;
               end
            end
            default: state_d = PS_EMPTY;
         endcase
      end
   end

   assign m_d = m_sel_skid ? s_q : in_data;

   flip_flop_D #(.WIDTH(WIDTH)) u_main (
      .clk   (clk),
      .reset (reset),
      .en    (m_en),
      .d     (m_d),
      .q     (out_data)
   );

   generate
      if (SKID != 0) begin : g_skid
         logic ready_q;

         flip_flop_D #(.WIDTH(WIDTH)) u_skid (
            .clk   (clk),
            .reset (reset),
            .en    (s_en),
            .d     (in_data),
            .q     (s_q)
         );

         // Ready comes straight from a flop so stalls never chain combinationally upstream.
         always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
               ready_q <= 1'b1;
            end else begin
               ready_q <= (state_d != PS_FULL);
            end
         end

         assign in_ready = ready_q;
      end else begin : g_no_skid
         assign s_q      = '0;
         assign in_ready = ~out_valid | out_ready;
      end
   endgenerate

endmodule
